// File: rtl/add_seq_arb_if.sv
// add_seq_arb_if: bundles the two requester ports and the result port of
// add_seq_arb.
//   slave  - the sequencer/arbiter side (takes requests, produces results)
//   master - the requesters plus the result consumer
// Signals:
//   reqN_valid/ready : request handshake for requester N (N = 0, 1)
//   reqN_a/b         : W-bit operands, reqN_sub = 1 selects a-b
//   res_valid/ready  : result handshake
//   res_data         : W-bit sum/difference
//   res_cout/ov/zero : carry out, signed overflow, result-is-zero
//   res_id           : requester that issued the result
interface add_seq_arb_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_cout;
  logic         res_ov;
  logic         res_zero;
  logic         res_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_cout, res_ov, res_zero, res_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_cout, res_ov, res_zero, res_id
  );
endinterface

// File: rtl/add_seq_arb.sv
// add_seq_arb: shares one 8-bit add slice between two requesters and uses
// it for multi-byte add/subtract, one byte per cycle, LSB byte first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - add_seq_arb_if.slave (request ports, result port)
// Parameter:
//   NBYTES - operand width in bytes (1..16), W = 8*NBYTES
module add_seq_arb #(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_arb_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          c;
  logic          last_id;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  data_q;
  logic          cout_q, ov_q, zero_q, id_q;

  logic          gnt_any, gnt_id;
  logic          rdy0, rdy1;
  logic          accept;
  logic          last_step;
  logic [W-1:0]  sel_a, sel_b;
  logic          sel_sub;
  logic [7:0]    a_byte, b_byte;
  logic [8:0]    sum9;
  logic [7:0]    sum7;
  logic [W-1:0]  data_nx;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_any = 1'b1;
      gnt_id  = ~last_id;
    end else if (bus.req0_valid) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b0;
    end else if (bus.req1_valid) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  always_comb begin
    sel_a   = gnt_id ? bus.req1_a   : bus.req0_a;
    sel_b   = gnt_id ? bus.req1_b   : bus.req0_b;
    sel_sub = gnt_id ? bus.req1_sub : bus.req0_sub;
  end

  // Byte slice; sum7 isolates the carry into bit 7 for the overflow flag.
  always_comb begin
    a_byte  = a_q[{idx, 3'b000} +: 8];
    b_byte  = b_q[{idx, 3'b000} +: 8];
    sum9    = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, c};
    sum7    = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, c};
    data_nx = data_q;
    data_nx[{idx, 3'b000} +: 8] = sum9[7:0];
  end

  assign last_step = (idx == LAST);

  always_comb begin
    state_nx = state;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        // Readies are withheld while reset is asserted.
        rdy0   = rst_n & gnt_any & ~gnt_id;
        rdy1   = rst_n & gnt_any &  gnt_id;
        accept = gnt_any;
        if (gnt_any) state_nx = RUN;
      end
      RUN: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      c       <= 1'b0;
      last_id <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
      id_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_q     <= sel_a;
        b_q     <= sel_sub ? ~sel_b : sel_b;
        c       <= sel_sub;
        last_id <= gnt_id;
        idx     <= '0;
      end
    end else if (state == RUN) begin
      data_q <= data_nx;
      c      <= sum9[8];
      if (last_step) begin
        cout_q <= sum9[8];
        ov_q   <= sum7[7] ^ sum9[8];
        zero_q <= (data_nx == '0);
        id_q   <= last_id;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = (state == DONE);
  assign bus.res_data   = data_q;
  assign bus.res_cout   = cout_q;
  assign bus.res_ov     = ov_q;
  assign bus.res_zero   = zero_q;
  assign bus.res_id     = id_q;
endmodule

// File: tb/tb_add_seq_arb.sv
module tb_add_seq_arb;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_seq_arb_if #(.NBYTES(NB)) bus ();
  add_seq_arb #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic sub);
    if (!id) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] d, input logic co,
                         input logic ov, input logic z, input logic id);
    chk({tag, "_valid"}, bus.res_valid, 1'b1);
    chk({tag, "_data"},  bus.res_data, d);
    chk({tag, "_cout"},  bus.res_cout, co);
    chk({tag, "_ov"},    bus.res_ov, ov);
    chk({tag, "_zero"},  bus.res_zero, z);
    chk({tag, "_id"},    bus.res_id, id);
  endtask

  // One operation with res_ready high; operands are scrambled right after
  // acceptance so the result relies on the latched copy.
  task automatic do_op(input string tag, input logic id, input logic [31:0] a,
                       input logic [31:0] b, input logic sub, input logic [31:0] d,
                       input logic co, input logic ov, input logic z);
    int n;
    drive(id, 1'b1, a, b, sub);
    #1;
    chk({tag, "_rdy"},   id ? bus.req1_ready : bus.req0_ready, 1'b1);
    chk({tag, "_nrdy"},  id ? bus.req0_ready : bus.req1_ready, 1'b0);
    tick();
    drive(id, 1'b0, 32'hDEADBEEF, 32'h12345678, ~sub);
    wait_res(n);
    chk({tag, "_lat"}, n, NB);
    chk_res(tag, d, co, ov, z, id);
    tick();
    chk({tag, "_gone"}, bus.res_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nacc, nres;
    int acc_edge[4];
    logic drop;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    bus.res_ready = 1'b1;
    tick();
    tick();

    chk("rst_valid", bus.res_valid, 1'b0);
    chk("rst_data",  bus.res_data, 32'h0);
    chk("rst_cout",  bus.res_cout, 1'b0);
    chk("rst_ov",    bus.res_ov, 1'b0);
    chk("rst_zero",  bus.res_zero, 1'b0);
    chk("rst_id",    bus.res_id, 1'b0);
    chk("rst_rdy0",  bus.req0_ready, 1'b0);
    chk("rst_rdy1",  bus.req1_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    do_op("add40", 1'b0, 32'h40404040, 32'h40404040, 1'b0, 32'h80808080, 1'b0, 1'b1, 1'b0);
    do_op("sub80", 1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    do_op("sub0",  1'b0, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    do_op("addff", 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // Both requesters held valid: alternating grants, accepts 6 cycles apart.
    drive(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
    drive(1'b1, 1'b1, 32'h00000010, 32'h00000003, 1'b1);
    nacc = 0;
    nres = 0;
    drop = 1'b0;
    #1;
    for (int cyc = 0; cyc < 80 && nres < 4; cyc++) begin
      if (drop) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drop = 1'b0;
        #1;
      end
      chk("arb_excl", bus.req0_ready & bus.req1_ready, 1'b0);
      if (bus.res_valid) begin
        chk("arb_id", bus.res_id, nres % 2);
        chk("arb_data", bus.res_data, (nres % 2) ? 32'h0000000D : 32'h33333333);
        nres++;
      end
      if (nacc < 4 && (bus.req0_ready || bus.req1_ready)) begin
        chk("arb_gnt", bus.req1_ready, nacc % 2);
        acc_edge[nacc] = cyc;
        nacc++;
        if (nacc == 4) drop = 1'b1;
      end
      tick();
    end
    chk("arb_nacc", nacc, 4);
    chk("arb_nres", nres, 4);
    for (int i = 1; i < 4; i++) chk("arb_space", acc_edge[i] - acc_edge[i-1], 6);
    tick();

    // Result back-pressure: held outputs, no accept while DONE.
    bus.res_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h00000001, 32'h00000001, 1'b0);
    #1;
    tick();
    drive(1'b0, 1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b1);
    drive(1'b1, 1'b1, 32'h00000007, 32'h00000008, 1'b0);
    wait_res(n);
    chk("hold_lat", n, NB);
    for (int i = 0; i < 10; i++) begin
      chk_res("hold", 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_rdy0", bus.req0_ready, 1'b0);
      chk("hold_rdy1", bus.req1_ready, 1'b0);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("rel_rdy1_done", bus.req1_ready, 1'b0);
    tick();
    chk("rel_valid", bus.res_valid, 1'b0);
    chk("rel_rdy1", bus.req1_ready, 1'b1);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    wait_res(n);
    chk("rel_lat", n, NB);
    chk_res("rel", 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset in the second RUN cycle discards the operation.
    drive(1'b0, 1'b1, 32'h00000005, 32'h00000006, 1'b0);
    #1;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    rst_n = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    chk("arst_valid", bus.res_valid, 1'b0);
    chk("arst_data",  bus.res_data, 32'h0);
    chk("arst_cout",  bus.res_cout, 1'b0);
    chk("arst_ov",    bus.res_ov, 1'b0);
    chk("arst_zero",  bus.res_zero, 1'b0);
    chk("arst_id",    bus.res_id, 1'b0);
    chk("arst_rdy0",  bus.req0_ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_hold_valid", bus.res_valid, 1'b0);
      chk("arst_hold_rdy1", bus.req1_ready, 1'b0);
    end
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    do_op("post", 1'b0, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
